// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, one-hot opclass bit indices,
// immediate format selector and the load-use hazard FSM state type.
package decode_pkg;

    localparam int OPCLASS_W = 11;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Bit positions inside o_opclass; LUI is bit 0.
    typedef enum logic [3:0] {
        OC_LUI    = 4'd0,
        OC_AUIPC  = 4'd1,
        OC_JAL    = 4'd2,
        OC_JALR   = 4'd3,
        OC_BRANCH = 4'd4,
        OC_LOAD   = 4'd5,
        OC_STORE  = 4'd6,
        OC_OPIMM  = 4'd7,
        OC_OP     = 4'd8,
        OC_FENCE  = 4'd9,
        OC_SYSTEM = 4'd10
    } opclass_idx_e;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef enum logic [0:0] {
        HZ_IDLE   = 1'b0,
        HZ_BUBBLE = 1'b1
    } hz_state_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for decode_stage.
// i_ce qualifies i_pc/i_instr; o_ce qualifies every o_* field; o_stall_decode holds fetch on the same cycle.
interface decode_stage_if import decode_pkg::*; #(
    parameter int REG_ADDR_W = 5
);
    logic [31:0]           i_pc;
    logic [31:0]           i_instr;
    logic                  i_ce;
    logic [31:0]           o_pc;
    logic [31:0]           o_instr;
    logic [REG_ADDR_W-1:0] o_rs1;
    logic [REG_ADDR_W-1:0] o_rs2;
    logic [REG_ADDR_W-1:0] o_rd;
    logic [2:0]            o_funct3;
    logic [6:0]            o_funct7;
    logic [31:0]           o_imm;
    logic [OPCLASS_W-1:0]  o_opclass;
    logic                  o_illegal;
    logic                  o_ce;
    logic                  o_stall_decode;

    modport slave (
        input  i_pc, i_instr, i_ce,
        output o_pc, o_instr, o_rs1, o_rs2, o_rd, o_funct3, o_funct7,
               o_imm, o_opclass, o_illegal, o_ce, o_stall_decode
    );

    modport master (
        output i_pc, i_instr, i_ce,
        input  o_pc, o_instr, o_rs1, o_rs2, o_rd, o_funct3, o_funct7,
               o_imm, o_opclass, o_illegal, o_ce, o_stall_decode
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: selects the RV32I immediate layout and sign-extends it.
module imm_gen import decode_pkg::*; (
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field split, immediate, one-hot opclass and load-use bubble insertion.
// Optional macro DECODE_ILLEGAL_CHECK_EN enables o_illegal detection (tied 0 otherwise).
module decode_stage import decode_pkg::*; #(
    parameter int REG_ADDR_W  = 5,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_is_load,
    decode_stage_if.slave         bus,
    output hz_state_e             dbg_state
);
    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [OPCLASS_W-1:0]  opclass_d;
    imm_fmt_e              fmt;
    logic [31:0]           imm_d;
    logic                  illegal_d;
    logic                  uses_rs2;
    logic                  hazard_raw;
    logic                  stall_decode;
    logic                  stall_bit;
    hz_state_e             state, state_nxt;

    assign opcode = bus.i_instr[6:0];
    assign f3     = bus.i_instr[14:12];
    assign f7     = bus.i_instr[31:25];
    assign rs1    = bus.i_instr[15 +: REG_ADDR_W];
    assign rs2    = bus.i_instr[20 +: REG_ADDR_W];

    always_comb begin
        opclass_d = '0;
        fmt       = FMT_NONE;
        case (opcode)
            OPC_LUI:    begin opclass_d[OC_LUI]    = 1'b1; fmt = FMT_U; end
            OPC_AUIPC:  begin opclass_d[OC_AUIPC]  = 1'b1; fmt = FMT_U; end
            OPC_JAL:    begin opclass_d[OC_JAL]    = 1'b1; fmt = FMT_J; end
            OPC_JALR:   begin opclass_d[OC_JALR]   = 1'b1; fmt = FMT_I; end
            OPC_BRANCH: begin opclass_d[OC_BRANCH] = 1'b1; fmt = FMT_B; end
            OPC_LOAD:   begin opclass_d[OC_LOAD]   = 1'b1; fmt = FMT_I; end
            OPC_STORE:  begin opclass_d[OC_STORE]  = 1'b1; fmt = FMT_S; end
            OPC_OPIMM:  begin opclass_d[OC_OPIMM]  = 1'b1; fmt = FMT_I; end
            OPC_OP:     begin opclass_d[OC_OP]     = 1'b1; fmt = FMT_NONE; end
            OPC_FENCE:  begin opclass_d[OC_FENCE]  = 1'b1; fmt = FMT_I; end
            OPC_SYSTEM: begin opclass_d[OC_SYSTEM] = 1'b1; fmt = FMT_I; end
            default:    begin opclass_d = '0; fmt = FMT_NONE; end
        endcase
    end

    imm_gen u_imm_gen (
        .instr (bus.i_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm_d)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    always_comb begin
        illegal_d = (opclass_d == '0) || (bus.i_instr[1:0] != 2'b11);
        if (opclass_d[OC_LOAD] && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) illegal_d = 1'b1;
        if (opclass_d[OC_STORE] && f3 > 3'd2) illegal_d = 1'b1;
        if (opclass_d[OC_BRANCH] && (f3 == 3'd2 || f3 == 3'd3)) illegal_d = 1'b1;
        if (opclass_d[OC_JALR] && f3 != 3'd0) illegal_d = 1'b1;
        // funct7=0x20 is only meaningful for SUB and SRA.
        if (opclass_d[OC_OP] && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
            illegal_d = 1'b1;
        if (opclass_d[OC_OPIMM] && f3 == 3'd1 && f7 != 7'h00) illegal_d = 1'b1;
        if (opclass_d[OC_OPIMM] && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) illegal_d = 1'b1;
    end
`else
    assign illegal_d = 1'b0;
`endif

    // The instruction in execute is valid exactly when this stage's o_ce is set.
    assign uses_rs2   = opclass_d[OC_BRANCH] | opclass_d[OC_STORE] | opclass_d[OC_OP];
    assign hazard_raw = LOAD_USE_EN & bus.i_ce & i_ex_is_load & bus.o_ce & (i_ex_rd != '0) &
                        ((i_ex_rd == rs1) | (uses_rs2 & (i_ex_rd == rs2)));

    always_ff @(posedge clk) begin
        if (rst) state <= HZ_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HZ_IDLE:   if (stall_decode && !stall) state_nxt = HZ_BUBBLE;
            HZ_BUBBLE: state_nxt = HZ_IDLE;
            default:   state_nxt = HZ_IDLE;
        endcase
    end

    always_comb begin
        stall_decode = hazard_raw && (state == HZ_IDLE) && !flush;
    end

    assign bus.o_stall_decode = stall_decode;
    assign stall_bit          = stall | stall_decode;
    assign dbg_state          = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_pc      <= '0;
            bus.o_instr   <= '0;
            bus.o_rs1     <= '0;
            bus.o_rs2     <= '0;
            bus.o_rd      <= '0;
            bus.o_funct3  <= '0;
            bus.o_funct7  <= '0;
            bus.o_imm     <= '0;
            bus.o_opclass <= '0;
            bus.o_illegal <= 1'b0;
            bus.o_ce      <= 1'b0;
        end else begin
            if (!stall_bit && bus.i_ce) begin
                bus.o_pc      <= bus.i_pc;
                bus.o_instr   <= bus.i_instr;
                bus.o_rs1     <= rs1;
                bus.o_rs2     <= rs2;
                bus.o_rd      <= bus.i_instr[7 +: REG_ADDR_W];
                bus.o_funct3  <= f3;
                bus.o_funct7  <= f7;
                bus.o_imm     <= imm_d;
                bus.o_opclass <= opclass_d;
                bus.o_illegal <= illegal_d;
            end
            // Own stall only: emit a bubble; downstream stall: hold.
            if (!stall_bit)  bus.o_ce <= bus.i_ce & ~flush;
            else if (!stall) bus.o_ce <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: issued instructions push expected decode
// results; a negedge monitor pops and compares whenever execute consumes o_ce.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [10:0] oc;
        logic        ill;
    } exp_t;

    localparam logic [10:0] C_LUI    = 11'(1) << int'(OC_LUI);
    localparam logic [10:0] C_JAL    = 11'(1) << int'(OC_JAL);
    localparam logic [10:0] C_BRANCH = 11'(1) << int'(OC_BRANCH);
    localparam logic [10:0] C_LOAD   = 11'(1) << int'(OC_LOAD);
    localparam logic [10:0] C_STORE  = 11'(1) << int'(OC_STORE);
    localparam logic [10:0] C_OPIMM  = 11'(1) << int'(OC_OPIMM);
    localparam logic [10:0] C_OP     = 11'(1) << int'(OC_OP);
`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_UNKNOWN = 1'b1;
`else
    localparam logic ILL_UNKNOWN = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst;
    logic      stall;
    logic      flush;
    logic [4:0] i_ex_rd;
    logic      i_ex_is_load;
    hz_state_e dbg_state;

    decode_stage_if bus ();

    decode_stage #(.REG_ADDR_W(5), .LOAD_USE_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .i_ex_rd      (i_ex_rd),
        .i_ex_is_load (i_ex_is_load),
        .bus          (bus),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   pops   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
        bus.i_pc    = pc;
        bus.i_instr = instr;
        bus.i_ce    = 1'b1;
    endtask

    task automatic drive_idle();
        bus.i_pc    = '0;
        bus.i_instr = '0;
        bus.i_ce    = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                         input logic [10:0] oc, input logic ill);
        exp_t e;
        drive(pc, instr);
        e.pc = pc; e.instr = instr; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.f7 = f7; e.imm = imm; e.oc = oc; e.ill = ill;
        exp_q.push_back(e);
        pushes++;
    endtask

    // Execute consumes the decoded instruction on a rising edge with o_ce set and no stall.
    always @(negedge clk) begin
        if (!rst && bus.o_ce && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual pc=0x%08h required no issue", bus.o_pc);
            end else begin
                mon_e = exp_q.pop_front();
                pops++;
                chk("mon_pc",      bus.o_pc,               mon_e.pc);
                chk("mon_instr",   bus.o_instr,            mon_e.instr);
                chk("mon_rd",      32'(bus.o_rd),          32'(mon_e.rd));
                chk("mon_rs1",     32'(bus.o_rs1),         32'(mon_e.rs1));
                chk("mon_rs2",     32'(bus.o_rs2),         32'(mon_e.rs2));
                chk("mon_funct3",  32'(bus.o_funct3),      32'(mon_e.f3));
                chk("mon_funct7",  32'(bus.o_funct7),      32'(mon_e.f7));
                chk("mon_imm",     bus.o_imm,              mon_e.imm);
                chk("mon_opclass", 32'(bus.o_opclass),     32'(mon_e.oc));
                chk("mon_illegal", 32'(bus.o_illegal),     32'(mon_e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; i_ex_is_load = 1'b0; i_ex_rd = '0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_o_ce",      32'(bus.o_ce),           32'd0);
        chk("rst_o_pc",      bus.o_pc,                32'd0);
        chk("rst_o_instr",   bus.o_instr,             32'd0);
        chk("rst_o_imm",     bus.o_imm,               32'd0);
        chk("rst_o_opclass", 32'(bus.o_opclass),      32'd0);
        chk("rst_o_rd",      32'(bus.o_rd),           32'd0);
        chk("rst_stall_dec", 32'(bus.o_stall_decode), 32'd0);
        chk("rst_state",     32'(dbg_state),          32'(HZ_IDLE));
        tick();
        rst = 1'b0;

        // Plain decode across formats
        issue(32'h100, 32'hFFF10093, 5'd1,  5'd2, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, C_OPIMM, 1'b0); tick();
        issue(32'h104, 32'h4000006F, 5'd0,  5'd0, 5'd0,  3'd0, 7'h20, 32'h00000400, C_JAL,   1'b0); tick();
        issue(32'h108, 32'hFE000E63, 5'h1C, 5'd0, 5'd0,  3'd0, 7'h7F, 32'hFFFFF7FC, C_BRANCH,1'b0); tick();
        issue(32'h10C, 32'h12345537, 5'd10, 5'd8, 5'd3,  3'd5, 7'h09, 32'h12345000, C_LUI,   1'b0); tick();
        issue(32'h110, 32'h0000007F, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0, 11'h0, ILL_UNKNOWN);   tick();
        issue(32'h114, 32'h0000A283, 5'd5,  5'd1, 5'd0,  3'd2, 7'h00, 32'h0, C_LOAD, 1'b0);         tick();

        // Load-use on rs1: one bubble, then ADD issues
        issue(32'h118, 32'h006281B3, 5'd3, 5'd5, 5'd6, 3'd0, 7'h00, 32'h0, C_OP, 1'b0);
        i_ex_is_load = 1'b1; i_ex_rd = 5'd5;
        @(negedge clk);
        chk("hz_add_stall", 32'(bus.o_stall_decode), 32'd1);
        chk("hz_add_state", 32'(dbg_state),          32'(HZ_IDLE));
        tick();
        i_ex_is_load = 1'b0;
        @(negedge clk);
        chk("bubble_o_ce",  32'(bus.o_ce),           32'd0);
        chk("bubble_state", 32'(dbg_state),          32'(HZ_BUBBLE));
        chk("bubble_stall", 32'(bus.o_stall_decode), 32'd0);
        chk("bubble_hold",  bus.o_pc,                32'h114);
        tick();

        // x0 load destination never stalls
        issue(32'h11C, 32'h006281B3, 5'd3, 5'd5, 5'd6, 3'd0, 7'h00, 32'h0, C_OP, 1'b0);
        i_ex_is_load = 1'b1; i_ex_rd = 5'd0;
        @(negedge clk);
        chk("hz_rd0_stall", 32'(bus.o_stall_decode), 32'd0);
        tick();

        // rs2 field of an I-type is an immediate, not a source
        issue(32'h120, 32'h00510093, 5'd1, 5'd2, 5'd5, 3'd0, 7'h00, 32'h5, C_OPIMM, 1'b0);
        i_ex_is_load = 1'b1; i_ex_rd = 5'd5;
        @(negedge clk);
        chk("hz_addi_stall", 32'(bus.o_stall_decode), 32'd0);
        tick();

        // Store data register rs2 does hazard
        issue(32'h124, 32'h00512023, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h0, C_STORE, 1'b0);
        @(negedge clk);
        chk("hz_sw_stall", 32'(bus.o_stall_decode), 32'd1);
        tick();
        i_ex_is_load = 1'b0;
        @(negedge clk);
        chk("hz_sw_bubble", 32'(bus.o_ce), 32'd0);
        tick();

        // Flush with no stall drops the instruction
        drive(32'h128, 32'h00510093);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("flush_o_ce", 32'(bus.o_ce), 32'd0);
        tick();

        // Flush concurrent with a hazard: flush wins
        issue(32'h12C, 32'h0000A283, 5'd5, 5'd1, 5'd0, 3'd2, 7'h00, 32'h0, C_LOAD, 1'b0);
        tick();
        drive(32'h130, 32'h006281B3);
        i_ex_is_load = 1'b1; i_ex_rd = 5'd5; flush = 1'b1;
        @(negedge clk);
        chk("flush_hz_stall", 32'(bus.o_stall_decode), 32'd0);
        tick();
        flush = 1'b0; i_ex_is_load = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("flush_hz_o_ce",  32'(bus.o_ce),   32'd0);
        chk("flush_hz_state", 32'(dbg_state),  32'(HZ_IDLE));
        tick();

        // Flush under downstream stall: o_ce and data held
        issue(32'h134, 32'h12345537, 5'd10, 5'd8, 5'd3, 3'd5, 7'h09, 32'h12345000, C_LUI, 1'b0);
        tick();
        stall = 1'b1; flush = 1'b1;
        drive(32'h138, 32'h00510093);
        tick();
        @(negedge clk);
        chk("stall_flush_o_ce",  32'(bus.o_ce), 32'd1);
        chk("stall_flush_pc",    bus.o_pc,      32'h134);
        chk("stall_flush_instr", bus.o_instr,   32'h12345537);
        tick();
        stall = 1'b0; flush = 1'b0;
        drive_idle();
        tick();
        @(negedge clk);
        chk("stall_release_o_ce", 32'(bus.o_ce), 32'd0);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("issue_count",   32'(pops),         32'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
